// File: rtl/fftmini_frame_writer_pkg.sv
// Shared constants and types for the FFT-mini frame writer and its detector.
package fftmini_frame_writer_pkg;

  localparam int FFT_LEN  = 1024;
  localparam int RAM_AW   = 9;
  localparam int SAMPLE_W = 12;
  localparam int DATA_W   = 16;
  localparam int RE_LSB   = 0;
  localparam int IM_LSB   = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } fw_state_t;

  // AXI-Stream complex beat: imag in the upper half, real in the lower half.
  typedef struct packed {
    logic [DATA_W-1:0] im;
    logic [DATA_W-1:0] re;
  } fft_beat_t;

endpackage

// File: rtl/fftmini_frame_writer_mag.sv
// Alpha-max-plus-beta-min magnitude: max(|re|,|im|) + min(|re|,|im|)/2.
module fft_mag_approx
  import fftmini_frame_writer_pkg::*;
(
  input  logic [DATA_W-1:0] re,
  input  logic [DATA_W-1:0] im,
  output logic [DATA_W-1:0] mag
);

  // One extra bit so that |-32768| = 32768 is representable.
  logic [DATA_W:0] re_x, im_x, a, b, mx, mn;

  assign re_x = {re[DATA_W-1], re};
  assign im_x = {im[DATA_W-1], im};
  assign a    = re[DATA_W-1] ? (~re_x + 1'b1) : re_x;
  assign b    = im[DATA_W-1] ? (~im_x + 1'b1) : im_x;
  assign mx   = (a > b) ? a : b;
  assign mn   = (a > b) ? b : a;
  // Worst case 32768 + 16384 = 49152 still fits DATA_W unsigned.
  assign mag  = DATA_W'(mx + (mn >> 1));

endmodule

// File: rtl/fftmini_frame_writer.sv
// Captures one frame, streams it through the FFT core, writes first-half bin magnitudes to RAM.
module fftmini_frame_writer
  import fftmini_frame_writer_pkg::*;
#(
  parameter int FFT_LEN  = fftmini_frame_writer_pkg::FFT_LEN,
  parameter int RAM_AW   = fftmini_frame_writer_pkg::RAM_AW,
  parameter int SAMPLE_W = fftmini_frame_writer_pkg::SAMPLE_W
) (
  input  logic                sys_clk,
  input  logic                sys_rstn,
  input  logic                fftmini_ctrl,
  output logic                fftmini_flag,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  output logic [31:0]         m_fft_tdata,
  output logic                m_fft_tvalid,
  output logic                m_fft_tlast,
  input  logic                m_fft_tready,
  input  logic [31:0]         s_fft_tdata,
  input  logic                s_fft_tvalid,
  input  logic                s_fft_tlast,
  output logic                s_fft_tready,
  output logic                ram_wr_en,
  output logic [RAM_AW-1:0]   ram_wr_addr,
  output logic [DATA_W-1:0]   ram_wr_data,
  output logic                overrun,
  output logic                tlast_err
);

  localparam int CNT_W = $clog2(FFT_LEN);

  fw_state_t         state, state_nxt;
  logic [CNT_W-1:0]  in_cnt, out_cnt;
  logic              hold_vld;
  logic [DATA_W-1:0] hold_data, sample_x, mag;
  fft_beat_t         res, beat_out;
  logic              in_acc, in_last_acc, out_beat, out_last_idx, out_end;

  assign res          = s_fft_tdata;
  assign sample_x     = {{(DATA_W-SAMPLE_W){adc_data[SAMPLE_W-1]}}, adc_data};
  assign in_acc       = (state == S_FEED) && hold_vld && m_fft_tready;
  assign in_last_acc  = in_acc && (in_cnt == CNT_W'(FFT_LEN-1));
  assign out_beat     = s_fft_tready && s_fft_tvalid;
  assign out_last_idx = (out_cnt == CNT_W'(FFT_LEN-1));
  assign out_end      = out_beat && (out_last_idx || s_fft_tlast);

  assign beat_out     = '{im: '0, re: hold_data};
  assign m_fft_tdata  = beat_out;
  assign m_fft_tvalid = hold_vld;
  assign m_fft_tlast  = hold_vld && (in_cnt == CNT_W'(FFT_LEN-1));

  fft_mag_approx u_mag (
    .re  (res.re),
    .im  (res.im),
    .mag (mag)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fftmini_flag = 1'b0;
    s_fft_tready = 1'b0;
    unique case (state)
      S_IDLE:  if (fftmini_ctrl) state_nxt = S_FEED;
      S_FEED: begin
        fftmini_flag = 1'b1;
        if (in_last_acc) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        fftmini_flag = 1'b1;
        s_fft_tready = 1'b1;
        if (out_end) state_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        // Flag stays high here so the registered final write lands inside the run.
        fftmini_flag = 1'b1;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      in_cnt      <= '0;
      out_cnt     <= '0;
      hold_vld    <= 1'b0;
      hold_data   <= '0;
      overrun     <= 1'b0;
      tlast_err   <= 1'b0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      ram_wr_en <= 1'b0;
      tlast_err <= 1'b0;
      case (state)
        S_IDLE: begin
          in_cnt   <= '0;
          out_cnt  <= '0;
          overrun  <= 1'b0;
          hold_vld <= 1'b0;
        end
        S_FEED: begin
          if (in_acc) in_cnt <= in_cnt + 1'b1;
          // A held beat is never overwritten; a sample arriving behind it is lost.
          if (adc_valid && !in_last_acc && (!hold_vld || in_acc)) begin
            hold_vld  <= 1'b1;
            hold_data <= sample_x;
          end else if (in_acc) begin
            hold_vld  <= 1'b0;
          end
          if (adc_valid && hold_vld && !in_acc) overrun <= 1'b1;
        end
        S_DRAIN: begin
          if (out_beat) begin
            out_cnt   <= out_cnt + 1'b1;
            tlast_err <= out_last_idx ^ s_fft_tlast;
            if (out_cnt[CNT_W-1:RAM_AW] == '0) begin
              ram_wr_en   <= 1'b1;
              ram_wr_addr <= out_cnt[RAM_AW-1:0];
              ram_wr_data <= mag;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
